// File: rtl/instr_encoder_pkg.sv
// Shared op_sel enumeration, opcode/funct constants and instruction-format
// structs used by the encoder control path and the combinational formatter.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_ORI  = 4'd6,
    OP_LW   = 4'd7,
    OP_SW   = 4'd8,
    OP_BNE  = 4'd9,
    OP_JMP  = 4'd10
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_JMP   = 6'd2;
  localparam logic [5:0] OPC_LW    = 6'd54;
  localparam logic [5:0] OPC_SW    = 6'd55;
  localparam logic [5:0] OPC_BNE   = 6'd56;
  localparam logic [5:0] OPC_ADDI  = 6'd57;
  localparam logic [5:0] OPC_ORI   = 6'd58;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_MUL = 6'd50;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] target;
  } jtype_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

endpackage

// File: rtl/instr_encoder_format.sv
// Combinational R/I/J instruction formatter; zero latency, no flow control.
// Illegal selections produce an all-zero word (the control path drops them).
module instr_format
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word
);

  rtype_t r;
  itype_t i;
  jtype_t j;

  always_comb begin
    r = '{opcode: OPC_RTYPE, rs: rs, rt: rt, rd: rd, shamt: 5'd0, funct: 6'd0};
    i = '{opcode: 6'd0, rs: rs, rt: rt, imm: imm};
    j = '{opcode: OPC_JMP, target: target};
    word = '0;
    case (op_sel_e'(op_sel))
      OP_ADD:  begin r.funct = FUNCT_ADD; word = r; end
      OP_SUB:  begin r.funct = FUNCT_SUB; word = r; end
      OP_MUL:  begin r.funct = FUNCT_MUL; word = r; end
      OP_AND:  begin r.funct = FUNCT_AND; word = r; end
      OP_OR:   begin r.funct = FUNCT_OR;  word = r; end
      OP_ADDI: begin i.opcode = OPC_ADDI; word = i; end
      OP_ORI:  begin i.opcode = OPC_ORI;  word = i; end
      OP_LW:   begin i.opcode = OPC_LW;   word = i; end
      OP_SW:   begin i.opcode = OPC_SW;   word = i; end
      OP_BNE:  begin i.opcode = OPC_BNE;  word = i; end
      OP_JMP:  word = j;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit words with sequential write addresses.
// Latency 1; valid/ready with a single output register, in_ready = !out_valid || out_ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};

  state_e      state;
  logic [31:0] fmt_word;
  logic        accept;
  logic        legal;
  logic        handshake;

  instr_format u_format (
    .op_sel (op_sel),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .target (target),
    .word   (fmt_word)
  );

  assign in_ready  = !clr && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign legal     = is_legal(op_sel);
  assign handshake = out_valid && out_ready;

  // Address advances on the handshake, so a word loaded in the same cycle lands on the next address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      instr_word  <= '0;
      instr_addr  <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      instr_word  <= '0;
      instr_addr  <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (handshake) begin
        instr_addr <= instr_addr + ADDR_ONE;
        if (word_count != WC_MAX) word_count <= word_count + WC_ONE;
      end
      case (state)
        IDLE: begin
          if (accept && legal) begin
            state      <= HOLD;
            out_valid  <= 1'b1;
            instr_word <= fmt_word;
          end
        end
        HOLD: begin
          if (handshake) begin
            if (accept && legal) begin
              instr_word <= fmt_word;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of single-word encodings plus
// hand-written flow-control, illegal-op, clr, reset and address-wrap sequences.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_word;
  logic [7:0]  instr_addr;
  logic        err_illegal;
  logic [8:0]  word_count;

  logic        s_clr;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [3:0]  s_op_sel;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_imm;
  logic [25:0] s_target;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_instr_word;
  logic [1:0]  s_instr_addr;
  logic        s_err_illegal;
  logic [2:0]  s_word_count;

  int n_chk;
  int n_fail;
  int exp_addr;

  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_word(instr_word), .instr_addr(instr_addr),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op_sel(s_op_sel), .rs(s_rs), .rt(s_rt), .rd(s_rd), .imm(s_imm), .target(s_target),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .instr_word(s_instr_word), .instr_addr(s_instr_addr),
    .err_illegal(s_err_illegal), .word_count(s_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [15:0] im, input logic [25:0] tg);
    op_sel = o; rs = a; rt = b; rd = c; imm = im; target = tg;
    in_valid = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_addr = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
    s_clr = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_op_sel = '0; s_rs = '0; s_rt = '0; s_rd = '0; s_imm = '0; s_target = '0;

    vecs[0] = '{"add",  4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820};
    vecs[1] = '{"sub",  4'd1,  5'd31, 5'd0,  5'd31, 16'h0000, 26'h0,       32'h03E0F822};
    vecs[2] = '{"mul",  4'd2,  5'd2,  5'd3,  5'd4,  16'h0000, 26'h0,       32'h00432032};
    vecs[3] = '{"and",  4'd3,  5'd5,  5'd6,  5'd7,  16'hFFFF, 26'h3FFFFFF, 32'h00A63824};
    vecs[4] = '{"or",   4'd4,  5'd0,  5'd0,  5'd1,  16'h0000, 26'h0,       32'h00000825};
    vecs[5] = '{"ori",  4'd6,  5'd1,  5'd2,  5'd31, 16'h1234, 26'h0,       32'hE8221234};
    vecs[6] = '{"sw",   4'd8,  5'd29, 5'd31, 5'd0,  16'h8000, 26'h0,       32'hDFBF8000};
    vecs[7] = '{"bne",  4'd9,  5'd3,  5'd4,  5'd0,  16'hFFFE, 26'h0,       32'hE064FFFE};
    vecs[8] = '{"jmp",  4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF};

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr_word", instr_word, 32'd0);
    chk("rst_instr_addr", {24'd0, instr_addr}, 32'd0);
    chk("rst_word_count", {23'd0, word_count}, 32'd0);
    chk("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #12;
    rst_n = 1'b1;
    tick;

    // Single-word encodings, one handshake each.
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, vecs[k].tgt);
      tick;
      in_valid = 1'b0;
      chk({vecs[k].nm, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[k].nm, "_word"}, instr_word, vecs[k].exp);
      chk({vecs[k].nm, "_addr"}, {24'd0, instr_addr}, 32'(exp_addr));
      tick;
      exp_addr++;
    end
    chk("table_word_count", {23'd0, word_count}, 32'd9);
    chk("table_idle", {31'd0, out_valid}, 32'd0);

    // clr restarts the program and blocks input.
    clr = 1'b1;
    #1;
    chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    clr = 1'b0;
    chk("clr_addr", {24'd0, instr_addr}, 32'd0);
    chk("clr_word_count", {23'd0, word_count}, 32'd0);

    // Back-to-back ADDI then LW, no bubble.
    drive(4'd5, 5'd0, 5'd5, 5'd0, 16'h0010, 26'h0);
    tick;
    chk("b2b_addi_word", instr_word, 32'hE4050010);
    chk("b2b_addi_addr", {24'd0, instr_addr}, 32'd0);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    drive(4'd7, 5'd4, 5'd6, 5'd0, 16'hFFFC, 26'h0);
    tick;
    in_valid = 1'b0;
    chk("b2b_lw_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_lw_word", instr_word, 32'hD886FFFC);
    chk("b2b_lw_addr", {24'd0, instr_addr}, 32'd1);
    tick;
    chk("b2b_done_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_word_count", {23'd0, word_count}, 32'd2);

    // JMP stalled by out_ready=0 for three cycles.
    out_ready = 1'b0;
    drive(4'd10, 5'd31, 5'd0, 5'd0, 16'h0000, 26'h40);
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_word", instr_word, 32'h08000040);
      chk("stall_addr", {24'd0, instr_addr}, 32'd2);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_word_count", {23'd0, word_count}, 32'd2);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    chk("stall_done_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_done_word_count", {23'd0, word_count}, 32'd3);
    chk("stall_done_addr", {24'd0, instr_addr}, 32'd3);

    // Illegal op_sel is consumed silently apart from a one-cycle error pulse.
    drive(4'd12, 5'd1, 5'd1, 5'd1, 16'h0000, 26'h0);
    tick;
    in_valid = 1'b0;
    chk("illegal_err", {31'd0, err_illegal}, 32'd1);
    chk("illegal_no_valid", {31'd0, out_valid}, 32'd0);
    tick;
    chk("illegal_err_clear", {31'd0, err_illegal}, 32'd0);
    chk("illegal_addr", {24'd0, instr_addr}, 32'd3);
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
    tick;
    in_valid = 1'b0;
    chk("post_illegal_word", instr_word, 32'h00221820);
    chk("post_illegal_addr", {24'd0, instr_addr}, 32'd3);
    tick;

    // clr with in_valid during HOLD discards the held word and the request.
    out_ready = 1'b0;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
    tick;
    chk("clr_hold_valid", {31'd0, out_valid}, 32'd1);
    clr = 1'b1;
    out_ready = 1'b1;
    drive(4'd4, 5'd0, 5'd0, 5'd1, 16'h0000, 26'h0);
    #1;
    chk("clr_hold_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_hold_dropped", {31'd0, out_valid}, 32'd0);
    chk("clr_hold_addr", {24'd0, instr_addr}, 32'd0);
    chk("clr_hold_word_count", {23'd0, word_count}, 32'd0);
    drive(4'd1, 5'd31, 5'd0, 5'd31, 16'h0000, 26'h0);
    tick;
    in_valid = 1'b0;
    chk("after_clr_word", instr_word, 32'h03E0F822);
    chk("after_clr_addr", {24'd0, instr_addr}, 32'd0);
    tick;

    // Asynchronous reset while holding a word.
    out_ready = 1'b0;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
    tick;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_word", instr_word, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    tick;

    // ADDR_W=2: five words wrap the address and saturate word_count at 4.
    s_op_sel = 4'd0; s_rs = 5'd1; s_rt = 5'd2; s_rd = 5'd3;
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 4) s_in_valid = 1'b0;
      chk("wrap_valid", {31'd0, s_out_valid}, 32'd1);
      chk("wrap_addr", {30'd0, s_instr_addr}, 32'(k % 4));
      chk("wrap_word_count", {29'd0, s_word_count}, 32'((k < 4) ? k : 4));
    end
    tick;
    chk("wrap_done_valid", {31'd0, s_out_valid}, 32'd0);
    chk("wrap_sat_word_count", {29'd0, s_word_count}, 32'd4);
    chk("wrap_final_addr", {30'd0, s_instr_addr}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
